// File: rtl/pwm_fade_pkg.sv
// rtl/pwm_fade_pkg.sv - shared types and default widths for the PWM fade controller
package pwm_fade_pkg;

    localparam int CNT_W_DEF  = 8;
    localparam int STEP_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } fade_state_t;

endpackage

// File: rtl/pwm_core.sv
// rtl/pwm_core.sv - free-running PWM counter, period tick and duty compare
module pwm_core
    import pwm_fade_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [CNT_W-1:0] duty,
    output logic             period_tick,
    output logic             PWM_out
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Both outputs decode registered state only, so they are glitch-free per cycle.
    assign period_tick = (cnt == {CNT_W{1'b1}});
    assign PWM_out     = (cnt < duty);

endmodule

// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - brightness request handshake and period-aligned duty ramping
module pwm_fade_ctrl
    import pwm_fade_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CNT_W-1:0]  req_level,
    input  logic [STEP_W-1:0] req_step,
    output logic              PWM_out,
    output logic [CNT_W-1:0]  duty_cur,
    output logic              busy,
    output logic              period_tick
);

    localparam logic [CNT_W-1:0] DUTY_MAX = {CNT_W{1'b1}};

    fade_state_t      state;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] step;

    logic             accept;
    logic [CNT_W:0]   up_sum;
    logic             up_done;
    logic [CNT_W-1:0] down_gap;
    logic             down_done;

    assign busy      = (state != IDLE);
    assign req_ready = (state == IDLE) && !rst_in;
    assign accept    = req_valid && req_ready;

    // One extra bit on the sum so a large step near full scale saturates instead of wrapping.
    assign up_sum    = {1'b0, duty_cur} + {1'b0, step};
    assign up_done   = (up_sum >= {1'b0, target});
    // Only consulted in RAMP_DOWN, where duty_cur > target, so the gap never underflows.
    assign down_gap  = duty_cur - target;
    assign down_done = (down_gap <= step);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            duty_cur <= '0;
            target   <= '0;
            step     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        target <= req_level;
                        step   <= (req_step == '0) ? DUTY_MAX : CNT_W'(req_step);
                        if (req_level > duty_cur) begin
                            state <= RAMP_UP;
                        end else if (req_level < duty_cur) begin
                            state <= RAMP_DOWN;
                        end
                    end
                end
                RAMP_UP: begin
                    if (period_tick) begin
                        if (up_done) begin
                            duty_cur <= target;
                            state    <= IDLE;
                        end else begin
                            duty_cur <= up_sum[CNT_W-1:0];
                        end
                    end
                end
                RAMP_DOWN: begin
                    if (period_tick) begin
                        if (down_done) begin
                            duty_cur <= target;
                            state    <= IDLE;
                        end else begin
                            duty_cur <= duty_cur - step;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    pwm_core #(
        .CNT_W (CNT_W)
    ) u_pwm_core (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .duty        (duty_cur),
        .period_tick (period_tick),
        .PWM_out     (PWM_out)
    );

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb/tb_pwm_fade_ctrl.sv - scoreboard bench for pwm_fade_ctrl against a per-period duty model
module tb_pwm_fade_ctrl;

    localparam int MAXC  = 255;
    localparam int BOUND = 20000;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_level = 8'd0;
    logic [3:0] req_step = 4'd0;
    logic       PWM_out;
    logic [7:0] duty_cur;
    logic       busy;
    logic       period_tick;

    always #5 clk_in = ~clk_in;

    pwm_fade_ctrl #(
        .CNT_W  (8),
        .STEP_W (4)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_level   (req_level),
        .req_step    (req_step),
        .PWM_out     (PWM_out),
        .duty_cur    (duty_cur),
        .busy        (busy),
        .period_tick (period_tick)
    );

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int tb_cnt = 0;
    int model_duty = 0;
    bit armed = 0;
    bit pending = 0;
    bit acc_flag = 0;
    int acc_base = 0;
    int acc_level = 0;
    int acc_step = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected duty after each period of a ramp, from plain saturating arithmetic.
    function automatic void push_ramp(input int start, input int tgt, input int stp);
        int d;
        int s;
        d = start;
        s = (stp == 0) ? MAXC : stp;
        while (d != tgt) begin
            if (tgt > d) d = (d + s > tgt) ? tgt : d + s;
            else         d = (d - s < tgt) ? tgt : d - s;
            exp_q.push_back(d);
        end
    endfunction

    // Feeder: turns an observed accept into the full expected duty sequence.
    always @(posedge clk_in) begin
        if (acc_flag) begin
            push_ramp(acc_base, acc_level, acc_step);
            acc_flag = 0;
        end
    end

    // Monitor: compares outputs every cycle, pops one expectation per updating period.
    always @(negedge clk_in) begin
        if (armed) begin
            if (pending) begin
                model_duty = exp_q.pop_front();
                pending = 0;
            end
            chk("duty_cur", 32'(duty_cur), 32'(model_duty));
            chk("period_tick", 32'(period_tick), 32'(tb_cnt == MAXC));
            chk("pwm_out", 32'(PWM_out), 32'(tb_cnt < model_duty));
            chk("busy", 32'(busy), 32'(exp_q.size() != 0));
            chk("req_ready", 32'(req_ready), 32'(!rst_in && exp_q.size() == 0));
        end
        if (rst_in) begin
            armed = 1;
            tb_cnt = 0;
            model_duty = 0;
            exp_q.delete();
            pending = 0;
            acc_flag = 0;
        end else if (armed) begin
            if (tb_cnt == MAXC && exp_q.size() != 0) pending = 1;
            if (req_valid && exp_q.size() == 0) begin
                acc_flag = 1;
                acc_base = model_duty;
                acc_level = int'(req_level);
                acc_step = int'(req_step);
            end
            tb_cnt = (tb_cnt + 1) % (MAXC + 1);
        end
    end

    task automatic issue(input int lvl, input int stp, input int at_cnt);
        int n;
        n = 0;
        do begin
            @(posedge clk_in);
            #1;
            n++;
        end while (at_cnt >= 0 && tb_cnt != at_cnt && n < 600);
        req_level = 8'(lvl);
        req_step = 4'(stp);
        req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!req_ready && n < BOUND);
        chk("accept_within_bound", 32'(n < BOUND), 32'd1);
        @(posedge clk_in);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while ((busy || !req_ready) && n < BOUND);
        chk("idle_within_bound", 32'(n < BOUND), 32'd1);
    endtask

    task automatic reset_pulse(input int cycles);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        repeat (cycles) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        issue(128, 0, -1);
        wait_idle();
        repeat (300) @(posedge clk_in);

        reset_pulse(2);
        issue(40, 16, -1);
        wait_idle();

        issue(200, 0, -1);
        wait_idle();
        issue(10, 15, -1);
        wait_idle();

        issue(250, 0, -1);
        wait_idle();
        issue(255, 15, -1);
        wait_idle();
        issue(250, 0, -1);
        wait_idle();
        issue(250, 5, -1);
        wait_idle();

        issue(60, 0, MAXC);
        wait_idle();

        issue(100, 10, -1);
        issue(30, 0, -1);
        wait_idle();

        issue(96, 0, -1);
        wait_idle();
        issue(200, 8, -1);
        repeat (50) @(posedge clk_in);
        reset_pulse(2);
        issue(77, 0, -1);
        wait_idle();

        for (int i = 0; i < 6; i++) begin
            int lvl;
            int stp;
            lvl = int'($urandom_range(0, 255));
            stp = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(10, 15));
            issue(lvl, stp, ($urandom_range(0, 4) == 0) ? MAXC : -1);
            wait_idle();
        end

        repeat (10) @(posedge clk_in);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
